// File: rtl/multi_lane_toll_controller.sv
// -----------------------------------------------------------------------------
// multi_lane_toll_controller
//
// Toll decision engine for NUM_LANES entry lanes that share one synchronous-read
// balance memory. Lane requests are arbitrated round-robin. The granted
// vehicle's balance is read and checked against the toll for its class. On a
// pass the reduced balance is written back and the lane's gate is opened for
// GATE_CYCLES cycles.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   lane_req       per-lane request level, held until lane_ack
//   lane_id        per-lane vehicle ID, lane i at [i*ID_W +: ID_W]
//   lane_class     per-lane class (0 car, 1 truck)
//   lane_ack       one-cycle accept pulse (READ cycle)
//   lane_done      one-cycle result pulse
//   lane_status    per lane 2 bits: 00 none, 01 pass, 10 fail (sticky)
//   lane_display   per lane 2 bits: 00 off, 01 green, 10 red (sticky)
//   gate_open      per-lane gate drive
//   mem_addr/mem_re/mem_rdata  balance read port (MEM_LAT cycles latency)
//   mem_we/mem_wdata           balance write-back
//   busy           high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module multi_lane_toll_controller #(
  parameter int NUM_LANES   = 2,
  parameter int ID_W        = 4,
  parameter int BAL_W       = 8,
  parameter int TOLL_CAR    = 50,
  parameter int TOLL_TRUCK  = 100,
  parameter int MEM_LAT     = 1,
  parameter int GATE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_LANES-1:0]      lane_req,
  input  logic [NUM_LANES*ID_W-1:0] lane_id,
  input  logic [NUM_LANES-1:0]      lane_class,
  output logic [NUM_LANES-1:0]      lane_ack,
  output logic [NUM_LANES-1:0]      lane_done,
  output logic [2*NUM_LANES-1:0]    lane_status,
  output logic [2*NUM_LANES-1:0]    lane_display,
  output logic [NUM_LANES-1:0]      gate_open,
  output logic [ID_W-1:0]           mem_addr,
  output logic                      mem_re,
  input  logic [BAL_W-1:0]          mem_rdata,
  output logic                      mem_we,
  output logic [BAL_W-1:0]          mem_wdata,
  output logic                      busy
);

  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int GATE_W    = $clog2(GATE_CYCLES + 1);
  localparam int WAIT_LOAD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam int CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  localparam logic [BAL_W-1:0]  TOLL_CAR_B   = BAL_W'(TOLL_CAR);
  localparam logic [BAL_W-1:0]  TOLL_TRUCK_B = BAL_W'(TOLL_TRUCK);
  localparam logic [GATE_W-1:0] GATE_LOAD    = GATE_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD     = CNT_W'(WAIT_LOAD);

  localparam bit CFG_OK = ((TOLL_CAR >> BAL_W) == 0) && ((TOLL_TRUCK >> BAL_W) == 0) &&
                          (TOLL_CAR >= 0) && (TOLL_TRUCK >= 0) &&
                          (MEM_LAT >= 1) && (GATE_CYCLES >= 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, CHECK} state_t;

  function automatic logic [BAL_W-1:0] toll_for(input logic cls);
    toll_for = cls ? TOLL_TRUCK_B : TOLL_CAR_B;
  endfunction

  state_t             state, state_nxt;
  logic [LANE_W-1:0]  ptr, ptr_nxt;
  logic [LANE_W-1:0]  grant_q, grant_nxt;
  logic [CNT_W-1:0]   wait_cnt, cnt_nxt;
  logic               cls_q;

  logic [NUM_LANES-1:0] ack_nxt, done_nxt, gate_load;
  logic [ID_W-1:0]      addr_nxt;
  logic                 re_nxt, we_nxt, busy_nxt;
  logic [BAL_W-1:0]     wdata_nxt;
  logic [BAL_W-1:0]     toll;
  logic                 pass;

  logic [1:0] status_q   [NUM_LANES];
  logic [1:0] display_q  [NUM_LANES];
  logic [1:0] status_nxt [NUM_LANES];
  logic [1:0] display_nxt[NUM_LANES];

  logic [GATE_W-1:0] gate_tmr     [NUM_LANES];
  logic [GATE_W-1:0] gate_tmr_nxt [NUM_LANES];

  logic [ID_W-1:0] id_arr [NUM_LANES];

  logic              arb_found;
  logic [LANE_W-1:0] arb_grant;
  logic [LANE_W-1:0] cand;
  int                sum;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign id_arr[i]              = lane_id[i*ID_W +: ID_W];
    assign lane_status[2*i +: 2]  = status_q[i];
    assign lane_display[2*i +: 2] = display_q[i];
  end

  a_cfg_ok: assert property (@(posedge clk) CFG_OK)
    else $error("multi_lane_toll_controller: toll wider than BAL_W or bad MEM_LAT/GATE_CYCLES");

  // Round-robin search: first requesting lane at or after ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = ptr;
    cand      = '0;
    sum       = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_LANES) sum = sum - NUM_LANES;
      cand = LANE_W'(sum);
      if (!arb_found && lane_req[cand]) begin
        arb_found = 1'b1;
        arb_grant = cand;
      end
    end
  end

  // FSM next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_q;
    cnt_nxt   = wait_cnt;
    addr_nxt  = mem_addr;
    ack_nxt   = '0;
    done_nxt  = '0;
    re_nxt    = 1'b0;
    we_nxt    = 1'b0;
    wdata_nxt = '0;
    gate_load = '0;
    toll      = toll_for(cls_q);
    pass      = (mem_rdata >= toll);
    for (int i = 0; i < NUM_LANES; i++) begin
      status_nxt[i]  = status_q[i];
      display_nxt[i] = display_q[i];
    end

    case (state)
      // Accept: ack, read strobe and address appear in the READ cycle.
      IDLE: begin
        if (arb_found) begin
          state_nxt         = READ;
          grant_nxt         = arb_grant;
          ptr_nxt           = (arb_grant == LANE_W'(NUM_LANES - 1)) ? '0 : arb_grant + 1'b1;
          ack_nxt[arb_grant] = 1'b1;
          re_nxt            = 1'b1;
          addr_nxt          = id_arr[arb_grant];
        end
      end
      // Memory has sampled the read; wait out the remaining latency.
      READ: begin
        if (MEM_LAT > 1) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = CHECK;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = CHECK;
        else                cnt_nxt   = wait_cnt - 1'b1;
      end
      // mem_rdata is valid now; decide and register results for the done cycle.
      CHECK: begin
        state_nxt          = IDLE;
        done_nxt[grant_q]  = 1'b1;
        if (pass) begin
          status_nxt[grant_q]  = 2'b01;
          display_nxt[grant_q] = 2'b01;
          we_nxt               = 1'b1;
          wdata_nxt            = mem_rdata - toll;
          gate_load[grant_q]   = 1'b1;
        end else begin
          status_nxt[grant_q]  = 2'b10;
          display_nxt[grant_q] = 2'b10;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Gate timers run independently of the FSM; a pass reloads, a fail leaves them.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gate_load[i])              gate_tmr_nxt[i] = GATE_LOAD;
      else if (gate_tmr[i] != '0)    gate_tmr_nxt[i] = gate_tmr[i] - 1'b1;
      else                           gate_tmr_nxt[i] = gate_tmr[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      wait_cnt  <= '0;
      lane_ack  <= '0;
      lane_done <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      gate_open <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        status_q[i]  <= '0;
        display_q[i] <= '0;
        gate_tmr[i]  <= '0;
      end
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_q   <= grant_nxt;
      wait_cnt  <= cnt_nxt;
      lane_ack  <= ack_nxt;
      lane_done <= done_nxt;
      mem_addr  <= addr_nxt;
      mem_re    <= re_nxt;
      mem_we    <= we_nxt;
      mem_wdata <= wdata_nxt;
      busy      <= busy_nxt;
      for (int i = 0; i < NUM_LANES; i++) begin
        status_q[i]  <= status_nxt[i];
        display_q[i] <= display_nxt[i];
        gate_tmr[i]  <= gate_tmr_nxt[i];
        gate_open[i] <= (gate_tmr_nxt[i] != '0);
      end
    end
  end

  // Vehicle class is datapath only; captured on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_found) cls_q <= lane_class[arb_grant];
  end

endmodule

// File: tb/tb_multi_lane_toll_controller.sv
module tb_multi_lane_toll_controller;

  logic clk = 1'b0;
  logic reset;

  initial forever #5 clk = ~clk;

  // DUT with MEM_LAT=1, GATE_CYCLES=4
  logic [1:0] req1, cls1, ack1, done1, gate1;
  logic [7:0] id1, rdata1, wdata1;
  logic [3:0] status1, display1, addr1;
  logic       re1, we1, busy1;

  // DUT with MEM_LAT=3, GATE_CYCLES=8
  logic [1:0] req3, cls3, ack3, done3, gate3;
  logic [7:0] id3, rdata3, wdata3;
  logic [3:0] status3, display3, addr3;
  logic       re3, we3, busy3;

  logic [7:0] mem1 [16];
  logic [7:0] mem3 [16];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  int tests = 0;
  int fails = 0;

  multi_lane_toll_controller #(
    .NUM_LANES(2), .ID_W(4), .BAL_W(8), .TOLL_CAR(50), .TOLL_TRUCK(100),
    .MEM_LAT(1), .GATE_CYCLES(4)
  ) dut1 (
    .clk(clk), .reset(reset), .lane_req(req1), .lane_id(id1), .lane_class(cls1),
    .lane_ack(ack1), .lane_done(done1), .lane_status(status1), .lane_display(display1),
    .gate_open(gate1), .mem_addr(addr1), .mem_re(re1), .mem_rdata(rdata1),
    .mem_we(we1), .mem_wdata(wdata1), .busy(busy1)
  );

  multi_lane_toll_controller #(
    .NUM_LANES(2), .ID_W(4), .BAL_W(8), .TOLL_CAR(50), .TOLL_TRUCK(100),
    .MEM_LAT(3), .GATE_CYCLES(8)
  ) dut3 (
    .clk(clk), .reset(reset), .lane_req(req3), .lane_id(id3), .lane_class(cls3),
    .lane_ack(ack3), .lane_done(done3), .lane_status(status3), .lane_display(display3),
    .gate_open(gate3), .mem_addr(addr3), .mem_re(re3), .mem_rdata(rdata3),
    .mem_we(we3), .mem_wdata(wdata3), .busy(busy3)
  );

  // Synchronous-read memory models with the configured latencies.
  always @(posedge clk) begin
    pipe1    <= re1 ? mem1[addr1] : 8'h00;
    pipe3[0] <= re3 ? mem3[addr3] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata1 = pipe1;
  assign rdata3 = pipe3[2];

  task automatic test_reset();
    reset = 1'b1;
    req1 = '0; id1 = '0; cls1 = '0;
    req3 = '0; id3 = '0; cls3 = '0;
    @(negedge clk);
    tests++;
    if ({ack1, done1, status1, display1, gate1, addr1, re1, we1, wdata1, busy1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_lat1: got ack=%b done=%b st=%b disp=%b gate=%b addr=%h re=%b we=%b wd=%h busy=%b want all 0",
               ack1, done1, status1, display1, gate1, addr1, re1, we1, wdata1, busy1);
    end
    tests++;
    if ({ack3, done3, status3, display3, gate3, addr3, re3, we3, wdata3, busy3} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_lat3: got nonzero output, busy=%b st=%b", busy3, status3);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy1); end
  endtask

  task automatic test_single_pass();
    int gcnt;
    mem1[3] = 8'd120;
    id1[3:0] = 4'd3; cls1[0] = 1'b0; req1[0] = 1'b1;
    @(negedge clk);  // READ cycle
    tests++; if (ack1 !== 2'b01) begin fails++; $display("FAIL pass_ack: got %b want 01", ack1); end
    tests++; if (re1 !== 1'b1) begin fails++; $display("FAIL pass_re: got %b want 1", re1); end
    tests++; if (addr1 !== 4'd3) begin fails++; $display("FAIL pass_addr: got %0d want 3", addr1); end
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL pass_busy: got %b want 1", busy1); end
    req1[0] = 1'b0;
    @(negedge clk);  // CHECK cycle
    tests++; if ({done1, ack1, we1} !== 5'b0) begin fails++; $display("FAIL pass_check_cycle: done=%b ack=%b we=%b want 0", done1, ack1, we1); end
    @(negedge clk);  // done cycle
    tests++; if (done1 !== 2'b01) begin fails++; $display("FAIL pass_done: got %b want 01", done1); end
    tests++; if (we1 !== 1'b1) begin fails++; $display("FAIL pass_we: got %b want 1", we1); end
    tests++; if (wdata1 !== 8'd70) begin fails++; $display("FAIL pass_wdata: got %0d want 70", wdata1); end
    tests++; if (status1[1:0] !== 2'b01) begin fails++; $display("FAIL pass_status0: got %b want 01", status1[1:0]); end
    tests++; if (display1[1:0] !== 2'b01) begin fails++; $display("FAIL pass_display0: got %b want 01", display1[1:0]); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL pass_busy_done: got %b want 0", busy1); end
    gcnt = gate1[0] ? 1 : 0;
    @(negedge clk);
    tests++; if ({we1, done1} !== 3'b0) begin fails++; $display("FAIL pass_pulse_width: we=%b done=%b want 0", we1, done1); end
    if (gate1[0]) gcnt++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (gate1[0]) gcnt++;
    end
    tests++; if (gcnt != 4) begin fails++; $display("FAIL pass_gate_cycles: got %0d want 4", gcnt); end
    tests++; if (status1[1:0] !== 2'b01) begin fails++; $display("FAIL pass_status_sticky: got %b want 01", status1[1:0]); end
  endtask

  task automatic test_truck_fail();
    int we_seen, done_at;
    logic gate_seen;
    mem1[5] = 8'd80;
    id1[7:4] = 4'd5; cls1[1] = 1'b1; req1[1] = 1'b1;
    we_seen = 0; done_at = 0; gate_seen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tests++; if (ack1 !== 2'b10) begin fails++; $display("FAIL truck_ack: got %b want 10", ack1); end
        req1[1] = 1'b0;
      end
      if (we1) we_seen++;
      if (gate1[1]) gate_seen = 1'b1;
      if (done1[1] && done_at == 0) done_at = k;
      if (k == 3) begin
        tests++; if (status1 !== 4'b1001) begin fails++; $display("FAIL truck_status: got %b want 1001", status1); end
        tests++; if (display1[3:2] !== 2'b10) begin fails++; $display("FAIL truck_display1: got %b want 10", display1[3:2]); end
      end
    end
    tests++; if (done_at != 3) begin fails++; $display("FAIL truck_done_cycle: got %0d want 3", done_at); end
    tests++; if (we_seen != 0) begin fails++; $display("FAIL truck_no_write: got %0d writes want 0", we_seen); end
    tests++; if (gate_seen !== 1'b0) begin fails++; $display("FAIL truck_gate_closed: got %b want 0", gate_seen); end
  endtask

  task automatic test_boundary();
    logic [3:0] ids  [3] = '{4'd1, 4'd2, 4'd4};
    logic       clss [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] bals [3] = '{8'd50, 8'd49, 8'd100};
    logic       exp_pass [3] = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      mem1[ids[t]] = bals[t];
      id1[3:0] = ids[t]; cls1[0] = clss[t]; req1[0] = 1'b1;
      @(negedge clk);
      req1[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++; if (done1 !== 2'b01) begin fails++; $display("FAIL boundary%0d_done: got %b want 01", t, done1); end
      tests++; if (we1 !== exp_pass[t]) begin fails++; $display("FAIL boundary%0d_we: got %b want %b", t, we1, exp_pass[t]); end
      if (exp_pass[t]) begin
        tests++; if (wdata1 !== 8'd0) begin fails++; $display("FAIL boundary%0d_wdata: got %0d want 0", t, wdata1); end
      end
      tests++;
      if (status1[1:0] !== (exp_pass[t] ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL boundary%0d_status: got %b want %b", t, status1[1:0], exp_pass[t] ? 2'b01 : 2'b10);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_arbitration();
    int order [3];
    int n, ack1_hits;
    logic both;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem1[6] = 8'd200; mem1[7] = 8'd200;
    order = '{-1, -1, -1};
    n = 0; ack1_hits = 0; both = 1'b0;
    id1 = {4'd7, 4'd6}; cls1 = 2'b00; req1 = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack1 == 2'b11) both = 1'b1;
      if (ack1[1]) begin
        ack1_hits++;
        tests++; if (re1 !== 1'b1) begin fails++; $display("FAIL arb_ack1_in_read: re=%b want 1", re1); end
        req1[1] = 1'b0;
      end
      if (ack1 != 2'b00 && n < 3) begin
        order[n] = ack1[1] ? 1 : 0;
        n++;
      end
      if (n == 3) req1[0] = 1'b0;
    end
    tests++; if (n != 3) begin fails++; $display("FAIL arb_grant_count: got %0d want 3", n); end
    tests++; if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      fails++; $display("FAIL arb_order: got %0d,%0d,%0d want 0,1,0", order[0], order[1], order[2]);
    end
    tests++; if (ack1_hits != 1) begin fails++; $display("FAIL arb_ack1_once: got %0d want 1", ack1_hits); end
    tests++; if (both !== 1'b0) begin fails++; $display("FAIL arb_onehot_ack: got %b want 0", both); end
  endtask

  task automatic test_latency_gate();
    int done_at1, done_at2, busy_cnt, gate_hi;
    logic [7:0] wd1, wd2;
    logic gate18;
    mem3[9] = 8'd250; mem3[10] = 8'd130;
    done_at1 = 0; done_at2 = 0; busy_cnt = 0; gate_hi = 0;
    wd1 = '0; wd2 = '0; gate18 = 1'b1;
    id3[3:0] = 4'd9; cls3[0] = 1'b0; req3[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (busy3) busy_cnt++;
      if (gate3[0]) gate_hi++;
      if (done3[0]) begin
        if (done_at1 == 0) begin done_at1 = k; wd1 = wdata3; end
        else begin done_at2 = k; wd2 = wdata3; end
      end
      if (k == 18) gate18 = gate3[0];
      if (k == 1) begin
        tests++; if (ack3 !== 2'b01 || re3 !== 1'b1) begin fails++; $display("FAIL lat_ack1: ack=%b re=%b want 01/1", ack3, re3); end
        req3[0] = 1'b0;
      end
      if (k == 5) begin id3[3:0] = 4'd10; req3[0] = 1'b1; end
      if (k == 6) begin
        tests++; if (ack3 !== 2'b01) begin fails++; $display("FAIL lat_ack2: got %b want 01", ack3); end
        req3[0] = 1'b0;
      end
    end
    tests++; if (done_at1 != 5) begin fails++; $display("FAIL lat_done1_cycle: got %0d want 5", done_at1); end
    tests++; if (done_at2 != 10) begin fails++; $display("FAIL lat_done2_cycle: got %0d want 10", done_at2); end
    tests++; if (busy_cnt != 8) begin fails++; $display("FAIL lat_busy_cycles: got %0d want 8", busy_cnt); end
    tests++; if (wd1 !== 8'd200) begin fails++; $display("FAIL lat_wdata1: got %0d want 200", wd1); end
    tests++; if (wd2 !== 8'd80) begin fails++; $display("FAIL lat_wdata2: got %0d want 80", wd2); end
    tests++; if (gate_hi != 13) begin fails++; $display("FAIL gate_reload_cycles: got %0d want 13", gate_hi); end
    tests++; if (gate18 !== 1'b0) begin fails++; $display("FAIL gate_reload_close: got %b want 0", gate18); end
  endtask

  task automatic test_reset_midop();
    int bad, done_at;
    logic [7:0] wd;
    logic [1:0] st;
    mem3[11] = 8'd200;
    id3 = {4'd11, 4'd0}; cls3 = 2'b10; req3 = 2'b10;
    @(negedge clk);
    tests++; if (ack3 !== 2'b10) begin fails++; $display("FAIL midop_ack: got %b want 10", ack3); end
    req3 = 2'b00;
    @(negedge clk);  // WAIT
    tests++; if (busy3 !== 1'b1) begin fails++; $display("FAIL midop_busy_wait: got %b want 1", busy3); end
    reset = 1'b1;
    #1;
    tests++;
    if ({ack3, done3, status3, display3, gate3, addr3, re3, we3, wdata3, busy3} !== '0) begin
      fails++;
      $display("FAIL midop_reset_outputs: st=%b disp=%b addr=%h busy=%b want all 0", status3, display3, addr3, busy3);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (we3 || done3 != 2'b00) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midop_aborted: got %0d result cycles want 0", bad); end
    done_at = 0; wd = '0; st = '0;
    req3 = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req3 = 2'b00;
      if (done3[1] && done_at == 0) begin done_at = k; wd = wdata3; st = status3[3:2]; end
    end
    tests++; if (done_at != 5) begin fails++; $display("FAIL midop_recover_done: got %0d want 5", done_at); end
    tests++; if (wd !== 8'd100) begin fails++; $display("FAIL midop_recover_wdata: got %0d want 100", wd); end
    tests++; if (st !== 2'b01) begin fails++; $display("FAIL midop_recover_status: got %b want 01", st); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_truck_fail();
    test_boundary();
    test_arbitration();
    test_latency_gate();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
